bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Central arbiter for the shared 32-master system bus; it sits beside the masters (the JTAG debug interface is master 31) and the slaves (SDRAM and others).
- Grants the bus to one requesting master at a time using round-robin.
- Tracks each transaction from begin to end.
- A watchdog terminates a hung transaction with a bus error and an end-of-transaction.
- Reports bus-idle and snoopable-burst status for caches and snoopers.

Parameters:
- TIMEOUT_CYCLES, 256: idle cycles (no dataValidIn or endTransactionIn) allowed inside an active transaction before the watchdog fires.
- GRANT_WAIT_CYCLES, 16: cycles allowed after a grant for the master to assert beginTransactionIn before the grant is abandoned.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- busRequests  in  32  per-master request; bit i = master i.
- busGrants  out  32  one-hot grant pulse.
- busErrorOut  out  1  watchdog error pulse driven onto the bus.
- endTransactionOut  out  1  watchdog end-of-transaction pulse.
- busIdle  out  1  high when no grant is pending and no transaction is active.
- snoopableBurst  out  1  high during an active snoopable burst.
- beginTransactionIn  in  1  OR'd bus begin strobe.
- endTransactionIn  in  1  OR'd bus end strobe.
- dataValidIn  in  1  OR'd bus data-valid strobe.
- addressDataIn  in  2  bits [31:30] of the bus address/data lines.
- burstSizeIn  in  8  bus burst size; value = beats minus 1.

Behaviour:
- Reset: busGrants=0, busErrorOut=0, endTransactionOut=0, snoopableBurst=0, busIdle=1, state=IDLE, round-robin pointer last=0, counters=0. Reset mid-transaction aborts immediately and emits no error or end pulse.
- FSM states: IDLE, GRANT, WAIT_BEGIN, ACTIVE, ERROR, END.
- IDLE:
  - If any busRequests bit is set, the winner is selected combinationally.
  - Search order: descending from (last-1) mod 32, wrapping. After reset, index 31 therefore has top priority.
  - Next cycle: busGrants = one-hot(winner) for exactly 1 cycle, last <= winner, state -> WAIT_BEGIN.
  - Grant latency is 1 clock after the request is sampled.
- WAIT_BEGIN:
  - beginTransactionIn -> ACTIVE, watchdog cleared.
  - After GRANT_WAIT_CYCLES with no begin -> IDLE; no error is raised.
  - Requests are ignored in this state.
- ACTIVE:
  - At the begin cycle, latch snoopableBurst = (addressDataIn==2'b00) && (burstSizeIn!=0). It is held until the transaction ends.
  - Any dataValidIn or beginTransactionIn cycle reloads the watchdog.
  - endTransactionIn -> IDLE; snoopableBurst cleared the same edge.
  - If the watchdog reaches TIMEOUT_CYCLES -> ERROR.
- ERROR: busErrorOut=1 for 1 cycle -> END.
- END: endTransactionOut=1 for 1 cycle -> IDLE.
- Simultaneous events:
  - endTransactionIn in the same cycle the watchdog expires: the end wins and no error is raised.
  - An external endTransactionIn in the ERROR cycle: END is skipped and the FSM goes straight to IDLE.
- An external error on the bus (slave error) is not an input. The master ends the transaction itself via endTransactionIn.
- busIdle = (state==IDLE). It is registered, so it goes low the cycle the grant is asserted.
- Back-to-back arbitration: a request present while leaving ACTIVE is evaluated in IDLE on the next cycle. The minimum gap between transactions is 1 idle cycle.
- All outputs are registered. Exactly one busGrants bit may be set at any time.

Decomposition:
- Shared package holds:
  - state enum;
  - NUM_MASTERS=32;
  - localparams for snoop region code (2'b00).
- Sub-module rr_priority_select (32-bit request vector plus last index in; one-hot winner plus index out) keeps the round-robin search separate from the FSM.

Test Plan:
- Single master: busRequests[31]=1 after reset -> busGrants=32'h8000_0000 for 1 cycle, 1 clock later; busIdle drops. Begin, one dataValidIn, then endTransactionIn -> busIdle=1, no busErrorOut.
- Round-robin:
  - busRequests=32'h8000_0001 held, each transaction completed -> grants alternate 31, 0, 31, 0.
  - A single requester at bit 5 after reset -> bit 5 granted.
- Snoop: begin with addressDataIn=2'b00, burstSizeIn=8'd7 -> snoopableBurst=1 until end. With addressDataIn=2'b01, or with burstSizeIn=0 -> stays 0.
- Watchdog: begin then silence -> exactly TIMEOUT_CYCLES later busErrorOut pulse, next cycle endTransactionOut pulse, then busIdle=1.
  - Repeat with endTransactionIn on the expiry cycle -> no error.
- Grant abandon: request then no begin -> after GRANT_WAIT_CYCLES back to IDLE; re-grant follows if the request is still held.
- Reset mid-ACTIVE: assert reset -> next edge all outputs at reset values, no error or end pulses; priority restarts at index 31.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the system bus arbiter: FSM states, master count
// and the snoopable address region code.
package bus_arbiter_pkg;

    localparam int NUM_MASTERS = 32;
    localparam int IDX_W       = $clog2(NUM_MASTERS);

    localparam logic [1:0] SNOOP_REGION = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WAIT_BEGIN,
        ACTIVE,
        ERROR,
        END
    } arb_state_t;

    // A burst is snoopable when it targets the cached region and has more than one beat.
    function automatic logic is_snoopable(input logic [1:0] region, input logic [7:0] burst_size);
        return (region == SNOOP_REGION) && (burst_size != 8'd0);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Round-robin winner search: descending from (last_idx - 1), wrapping, so the
// previous winner gets the lowest priority.
module rr_priority_select
    import bus_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] requests,
    input  logic [IDX_W-1:0]       last_idx,
    output logic [NUM_MASTERS-1:0] winner_onehot,
    output logic [IDX_W-1:0]       winner_idx,
    output logic                   any_request
);

    // rotated[k] is the request of master (last_idx - 1 - k) mod NUM_MASTERS
    logic [NUM_MASTERS-1:0] rotated;
    logic                   found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_rotate
            localparam logic [IDX_W-1:0] OFFSET = IDX_W'(gi + 1);
            assign rotated[gi] = requests[last_idx - OFFSET];
        end
    endgenerate

    always_comb begin
        found         = 1'b0;
        winner_idx    = '0;
        winner_onehot = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && rotated[k]) begin
                found      = 1'b1;
                winner_idx = last_idx - IDX_W'(k + 1);
            end
        end
        winner_onehot[winner_idx] = found;
        any_request               = found;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Central round-robin arbiter for the shared 32-master bus, with transaction
// tracking, grant-abandon timer and a watchdog that terminates hung transactions.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES    = 256,
    parameter int GRANT_WAIT_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] busRequests,
    output logic [NUM_MASTERS-1:0] busGrants,
    output logic                   busErrorOut,
    output logic                   endTransactionOut,
    output logic                   busIdle,
    output logic                   snoopableBurst,
    input  logic                   beginTransactionIn,
    input  logic                   endTransactionIn,
    input  logic                   dataValidIn,
    input  logic [1:0]             addressDataIn,
    input  logic [7:0]             burstSizeIn
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW_W = $clog2(GRANT_WAIT_CYCLES + 1);

    arb_state_t             state_reg;
    logic [IDX_W-1:0]       last_reg;
    logic [NUM_MASTERS-1:0] grants_reg;
    logic                   bus_error_reg;
    logic                   end_out_reg;
    logic                   idle_reg;
    logic                   snoop_reg;
    logic [WD_W-1:0]        watchdog_reg;
    logic [GW_W-1:0]        grant_wait_reg;

    logic [NUM_MASTERS-1:0] winner_onehot;
    logic [IDX_W-1:0]       winner_idx;
    logic                   any_request;

    rr_priority_select u_select (
        .requests      (busRequests),
        .last_idx      (last_reg),
        .winner_onehot (winner_onehot),
        .winner_idx    (winner_idx),
        .any_request   (any_request)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_reg       <= '0;
            grants_reg     <= '0;
            bus_error_reg  <= 1'b0;
            end_out_reg    <= 1'b0;
            idle_reg       <= 1'b1;
            snoop_reg      <= 1'b0;
            watchdog_reg   <= '0;
            grant_wait_reg <= '0;
        end else begin
            // Grant, error and end outputs are single-cycle pulses
            grants_reg    <= '0;
            bus_error_reg <= 1'b0;
            end_out_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_request) begin
                        grants_reg     <= winner_onehot;
                        last_reg       <= winner_idx;
                        grant_wait_reg <= '0;
                        idle_reg       <= 1'b0;
                        state_reg      <= WAIT_BEGIN;
                    end
                end
                WAIT_BEGIN: begin
                    if (beginTransactionIn) begin
                        watchdog_reg <= '0;
                        snoop_reg    <= is_snoopable(addressDataIn, burstSizeIn);
                        state_reg    <= ACTIVE;
                    end else if (grant_wait_reg == GW_W'(GRANT_WAIT_CYCLES - 1)) begin
                        idle_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        grant_wait_reg <= grant_wait_reg + 1'b1;
                    end
                end
                ACTIVE: begin
                    // A master end beats a watchdog expiry in the same cycle
                    if (endTransactionIn) begin
                        snoop_reg <= 1'b0;
                        idle_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else if (dataValidIn || beginTransactionIn) begin
                        watchdog_reg <= '0;
                    end else if (watchdog_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        snoop_reg     <= 1'b0;
                        bus_error_reg <= 1'b1;
                        state_reg     <= ERROR;
                    end else begin
                        watchdog_reg <= watchdog_reg + 1'b1;
                    end
                end
                ERROR: begin
                    if (endTransactionIn) begin
                        idle_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        end_out_reg <= 1'b1;
                        state_reg   <= END;
                    end
                end
                END: begin
                    idle_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    idle_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busGrants         = grants_reg;
    assign busErrorOut       = bus_error_reg;
    assign endTransactionOut = end_out_reg;
    assign busIdle           = idle_reg;
    assign snoopableBurst    = snoop_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: scenario tasks with randomized traffic
// checked against a round-robin / transaction-timing reference model.
module tb_bus_arbiter;

    localparam int T  = 256;
    localparam int GW = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] busRequests;
    logic [31:0] busGrants;
    logic        busErrorOut;
    logic        endTransactionOut;
    logic        busIdle;
    logic        snoopableBurst;
    logic        beginTransactionIn;
    logic        endTransactionIn;
    logic        dataValidIn;
    logic [1:0]  addressDataIn;
    logic [7:0]  burstSizeIn;

    int errors = 0;
    int checks = 0;
    int model_last = 0;

    always #5 clock = ~clock;

    bus_arbiter #(.TIMEOUT_CYCLES(T), .GRANT_WAIT_CYCLES(GW)) dut (
        .clock              (clock),
        .reset              (reset),
        .busRequests        (busRequests),
        .busGrants          (busGrants),
        .busErrorOut        (busErrorOut),
        .endTransactionOut  (endTransactionOut),
        .busIdle            (busIdle),
        .snoopableBurst     (snoopableBurst),
        .beginTransactionIn (beginTransactionIn),
        .endTransactionIn   (endTransactionIn),
        .dataValidIn        (dataValidIn),
        .addressDataIn      (addressDataIn),
        .burstSizeIn        (burstSizeIn)
    );

    // Reference rule: first requester found walking down from last-1, wrapping
    function automatic int rr_pick(input logic [31:0] req, input int last);
        for (int k = 1; k <= 32; k++) begin
            int idx;
            idx = ((last - k) % 32 + 32) % 32;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        busRequests = '1;
        tick();
        tick();
        checks++;
        if ({busGrants, busErrorOut, endTransactionOut, busIdle, snoopableBurst} !== {32'h0, 4'b0010})
            begin errors++; $display("FAIL reset_state: got grants=%h err=%b end=%b idle=%b snoop=%b, expected grants=0 err=0 end=0 idle=1 snoop=0", busGrants, busErrorOut, endTransactionOut, busIdle, snoopableBurst); end
        reset = 1'b0;
        busRequests = '0;
        model_last = 0;
        tick();
        $display("reset: idle=%b grants=%h", busIdle, busGrants);
    endtask

    task automatic test_single_master();
        busRequests = 32'h8000_0000;
        tick();
        checks++;
        if (busGrants !== 32'h8000_0000 || busIdle !== 1'b0)
            begin errors++; $display("FAIL single_grant: got grants=%h idle=%b, expected 80000000 idle=0", busGrants, busIdle); end
        model_last = 31;
        busRequests = '0;
        tick();
        checks++;
        if (busGrants !== 32'h0)
            begin errors++; $display("FAIL single_grant_pulse: got grants=%h, expected 00000000", busGrants); end
        beginTransactionIn = 1'b1; addressDataIn = 2'b01; burstSizeIn = 8'd3;
        tick();
        beginTransactionIn = 1'b0; dataValidIn = 1'b1;
        tick();
        dataValidIn = 1'b0; endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        checks++;
        if (busIdle !== 1'b1 || busErrorOut !== 1'b0 || snoopableBurst !== 1'b0)
            begin errors++; $display("FAIL single_end: got idle=%b err=%b snoop=%b, expected idle=1 err=0 snoop=0", busIdle, busErrorOut, snoopableBurst); end
        $display("single master: txn done idle=%b", busIdle);
    endtask

    task automatic test_round_robin();
        int w;
        reset = 1'b1; tick(); reset = 1'b0; model_last = 0;
        busRequests = 32'h8000_0001;
        for (int n = 0; n < 4; n++) begin
            w = rr_pick(busRequests, model_last);
            tick();
            checks++;
            if (busGrants !== (32'b1 << w))
                begin errors++; $display("FAIL rr_grant_%0d: got %h, expected %h", n, busGrants, 32'b1 << w); end
            $display("round robin %0d: grant=%h", n, busGrants);
            model_last = w;
            beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0;
            endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0;
            checks++;
            if (busIdle !== 1'b1 || busGrants !== 32'h0)
                begin errors++; $display("FAIL rr_gap_%0d: got idle=%b grants=%h, expected idle=1 grants=0", n, busIdle, busGrants); end
        end
        reset = 1'b1; tick(); reset = 1'b0; model_last = 0;
        busRequests = 32'h0000_0020;
        tick();
        checks++;
        if (busGrants !== 32'h0000_0020)
            begin errors++; $display("FAIL rr_bit5: got %h, expected 00000020", busGrants); end
        model_last = 5;
        busRequests = '0;
        beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0;
        endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0;
    endtask

    task automatic test_snoop();
        logic [1:0] addr_tab [3];
        logic [7:0] burst_tab[3];
        logic       exp_tab  [3];
        int w;
        addr_tab  = '{2'b00, 2'b01, 2'b00};
        burst_tab = '{8'd7, 8'd7, 8'd0};
        exp_tab   = '{1'b1, 1'b0, 1'b0};
        for (int n = 0; n < 3; n++) begin
            busRequests = 32'h0000_1000;
            w = rr_pick(busRequests, model_last);
            tick();
            model_last = w;
            busRequests = '0;
            addressDataIn = addr_tab[n]; burstSizeIn = burst_tab[n]; beginTransactionIn = 1'b1;
            tick();
            beginTransactionIn = 1'b0; addressDataIn = 2'b00; burstSizeIn = 8'hff;
            checks++;
            if (snoopableBurst !== exp_tab[n])
                begin errors++; $display("FAIL snoop_begin_%0d: got %b, expected %b", n, snoopableBurst, exp_tab[n]); end
            dataValidIn = 1'b1; tick(); dataValidIn = 1'b0; tick();
            checks++;
            if (snoopableBurst !== exp_tab[n])
                begin errors++; $display("FAIL snoop_hold_%0d: got %b, expected %b", n, snoopableBurst, exp_tab[n]); end
            endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0;
            checks++;
            if (snoopableBurst !== 1'b0)
                begin errors++; $display("FAIL snoop_clear_%0d: got %b, expected 0", n, snoopableBurst); end
            $display("snoop case %0d: addr=%b burst=%0d", n, addr_tab[n], burst_tab[n]);
        end
    endtask

    task automatic test_random_traffic();
        logic [31:0] req;
        logic [1:0]  a;
        logic [7:0]  b;
        logic        exp_snoop;
        int          w, beats;
        for (int n = 0; n < 24; n++) begin
            req = $urandom;
            if ($urandom_range(0, 2) == 0) req = 32'b1 << $urandom_range(0, 31);
            if (req == 32'h0) req = 32'h1;
            w = rr_pick(req, model_last);
            busRequests = req;
            tick();
            checks++;
            if (busGrants !== (32'b1 << w) || busIdle !== 1'b0)
                begin errors++; $display("FAIL rand_grant_%0d: req=%h got grants=%h idle=%b, expected %h idle=0", n, req, busGrants, busIdle, 32'b1 << w); end
            $display("random txn %0d: req=%h grant=%h", n, req, busGrants);
            model_last = w;
            busRequests = $urandom;
            a = 2'($urandom_range(0, 3));
            b = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'd0;
            exp_snoop = (a == 2'b00) && (b != 8'd0);
            addressDataIn = a; burstSizeIn = b; beginTransactionIn = 1'b1;
            tick();
            beginTransactionIn = 1'b0; addressDataIn = 2'($urandom); burstSizeIn = 8'($urandom);
            checks++;
            if (snoopableBurst !== exp_snoop || busIdle !== 1'b0)
                begin errors++; $display("FAIL rand_snoop_%0d: got snoop=%b idle=%b, expected snoop=%b idle=0", n, snoopableBurst, busIdle, exp_snoop); end
            beats = $urandom_range(0, 6);
            for (int i = 0; i < beats; i++) begin
                dataValidIn = 1'($urandom_range(0, 1));
                tick();
                checks++;
                if (snoopableBurst !== exp_snoop || busErrorOut !== 1'b0 || busGrants !== 32'h0)
                    begin errors++; $display("FAIL rand_active_%0d: got snoop=%b err=%b grants=%h, expected snoop=%b err=0 grants=0", n, snoopableBurst, busErrorOut, busGrants, exp_snoop); end
            end
            dataValidIn = 1'b0; endTransactionIn = 1'b1;
            tick();
            endTransactionIn = 1'b0;
            checks++;
            if (snoopableBurst !== 1'b0 || busIdle !== 1'b1 || endTransactionOut !== 1'b0)
                begin errors++; $display("FAIL rand_end_%0d: got snoop=%b idle=%b endout=%b, expected 0 1 0", n, snoopableBurst, busIdle, endTransactionOut); end
        end
        busRequests = '0;
        tick();
    endtask

    // Error must appear T+1 observations after the last begin/data-valid cycle
    task automatic test_watchdog();
        int w, seen;
        for (int sc = 0; sc < 2; sc++) begin
            busRequests = 32'h0000_0008;
            w = rr_pick(busRequests, model_last);
            tick();
            model_last = w;
            busRequests = '0;
            beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0;
            if (sc == 1) begin
                repeat ($urandom_range(10, 200)) tick();
                dataValidIn = 1'b1; tick(); dataValidIn = 1'b0;
            end
            seen = 0;
            for (int c = 1; c <= T + 4 && seen == 0; c++) begin
                if (busErrorOut === 1'b1) seen = c;
                else tick();
            end
            checks++;
            if (seen != T + 1)
                begin errors++; $display("FAIL watchdog_latency_%0d: error after %0d cycles, expected %0d", sc, seen, T + 1); end
            tick();
            checks++;
            if (endTransactionOut !== 1'b1 || busErrorOut !== 1'b0 || busIdle !== 1'b0)
                begin errors++; $display("FAIL watchdog_end_%0d: got endout=%b err=%b idle=%b, expected 1 0 0", sc, endTransactionOut, busErrorOut, busIdle); end
            tick();
            checks++;
            if (busIdle !== 1'b1 || endTransactionOut !== 1'b0)
                begin errors++; $display("FAIL watchdog_idle_%0d: got idle=%b endout=%b, expected 1 0", sc, busIdle, endTransactionOut); end
            $display("watchdog scenario %0d: error seen after %0d cycles", sc, seen);
        end
    endtask

    task automatic test_watchdog_races();
        int w;
        busRequests = 32'h0000_0040;
        w = rr_pick(busRequests, model_last);
        tick();
        model_last = w;
        busRequests = '0;
        beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0;
        repeat (T - 1) tick();
        endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0;
        checks++;
        if (busErrorOut !== 1'b0 || busIdle !== 1'b1)
            begin errors++; $display("FAIL race_expiry_end: got err=%b idle=%b, expected 0 1", busErrorOut, busIdle); end
        tick();
        checks++;
        if (busErrorOut !== 1'b0 || endTransactionOut !== 1'b0)
            begin errors++; $display("FAIL race_expiry_after: got err=%b endout=%b, expected 0 0", busErrorOut, endTransactionOut); end
        $display("race: end on expiry cycle, err=%b", busErrorOut);
        busRequests = 32'h0000_0040;
        w = rr_pick(busRequests, model_last);
        tick();
        model_last = w;
        busRequests = '0;
        beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0;
        repeat (T) tick();
        checks++;
        if (busErrorOut !== 1'b1)
            begin errors++; $display("FAIL race_error_cycle: got err=%b, expected 1", busErrorOut); end
        endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0;
        checks++;
        if (endTransactionOut !== 1'b0 || busIdle !== 1'b1)
            begin errors++; $display("FAIL race_error_end: got endout=%b idle=%b, expected 0 1", endTransactionOut, busIdle); end
        $display("race: end in error cycle, endout=%b idle=%b", endTransactionOut, busIdle);
    endtask

    task automatic test_grant_abandon();
        int w, w2, regrant;
        busRequests = 32'h0000_0200;
        w = rr_pick(busRequests, model_last);
        tick();
        checks++;
        if (busGrants !== (32'b1 << w))
            begin errors++; $display("FAIL abandon_grant: got %h, expected %h", busGrants, 32'b1 << w); end
        model_last = w;
        w2 = rr_pick(busRequests, model_last);
        regrant = 0;
        for (int c = 1; c <= GW + 4 && regrant == 0; c++) begin
            tick();
            if (c == GW) begin
                checks++;
                if (busIdle !== 1'b1 || busErrorOut !== 1'b0)
                    begin errors++; $display("FAIL abandon_idle: got idle=%b err=%b, expected 1 0", busIdle, busErrorOut); end
            end
            if (busGrants !== 32'h0) regrant = c;
        end
        checks++;
        if (regrant != GW + 1 || busGrants !== (32'b1 << w2))
            begin errors++; $display("FAIL abandon_regrant: got grant %h after %0d cycles, expected %h after %0d", busGrants, regrant, 32'b1 << w2, GW + 1); end
        $display("abandon: regrant after %0d cycles", regrant);
        model_last = w2;
        busRequests = '0;
        repeat (GW) tick();
        checks++;
        if (busIdle !== 1'b1)
            begin errors++; $display("FAIL abandon_final_idle: got idle=%b, expected 1", busIdle); end
        tick();
        checks++;
        if (busGrants !== 32'h0 || busIdle !== 1'b1)
            begin errors++; $display("FAIL abandon_no_regrant: got grants=%h idle=%b, expected 0 1", busGrants, busIdle); end
    endtask

    task automatic test_reset_mid_active();
        int w;
        busRequests = 32'h0000_0004;
        w = rr_pick(busRequests, model_last);
        tick();
        model_last = w;
        busRequests = '0;
        addressDataIn = 2'b00; burstSizeIn = 8'd15; beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        repeat (5) tick();
        checks++;
        if (snoopableBurst !== 1'b1)
            begin errors++; $display("FAIL midreset_pre_snoop: got %b, expected 1", snoopableBurst); end
        reset = 1'b1;
        busRequests = 32'h8000_0004;
        tick();
        checks++;
        if ({busGrants, busErrorOut, endTransactionOut, busIdle, snoopableBurst} !== {32'h0, 4'b0010})
            begin errors++; $display("FAIL midreset_state: got grants=%h err=%b end=%b idle=%b snoop=%b, expected 0 0 0 1 0", busGrants, busErrorOut, endTransactionOut, busIdle, snoopableBurst); end
        reset = 1'b0;
        model_last = 0;
        w = rr_pick(busRequests, model_last);
        tick();
        checks++;
        if (busGrants !== (32'b1 << w) || busErrorOut !== 1'b0 || endTransactionOut !== 1'b0)
            begin errors++; $display("FAIL midreset_regrant: got grants=%h err=%b end=%b, expected %h 0 0", busGrants, busErrorOut, endTransactionOut, 32'b1 << w); end
        $display("reset mid-active: first grant after reset=%h", busGrants);
        model_last = w;
        busRequests = '0;
        beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0;
        endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        busRequests = '0;
        beginTransactionIn = 1'b0;
        endTransactionIn = 1'b0;
        dataValidIn = 1'b0;
        addressDataIn = 2'b00;
        burstSizeIn = 8'd0;
        test_reset();
        test_single_master();
        test_round_robin();
        test_snoop();
        test_random_traffic();
        test_watchdog();
        test_watchdog_races();
        test_grant_abandon();
        test_reset_mid_active();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
